// File: rtl/memory_cycle.sv
// MEM stage of the RV32I pipeline: sizes and aligns loads/stores onto a req/ready
// data bus, stalls upstream while an access is outstanding, and registers MEM/WB.
module memory_cycle #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RDM,
    input  logic [31:0] PCPlus4M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RDW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state, nextState;
    logic [CNT_W-1:0]   waitCnt;
    logic               isLoad, isStore, isAccess, misalign, accessOk, timeout;
    logic [1:0]         offs;
    logic [3:0]         fmtBe;
    logic [31:0]        fmtWdata;
    logic               reqRaw, stallRaw, busErrRaw, misRaw;
    logic               latchWe_p0;
    logic [31:0]        latchAddr_p0, latchWdata_p0;
    logic [3:0]         latchBe_p0;

    function automatic logic [3:0] storeBe(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   storeBe = 4'b0001 << off;
            2'b01:   storeBe = 4'b0011 << off;
            default: storeBe = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] storeData(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   storeData = {4{d[7:0]}};
            2'b01:   storeData = {2{d[15:0]}};
            default: storeData = d;
        endcase
    endfunction

    function automatic logic [31:0] loadExtract(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0]        shifted;
        logic signed [7:0]  byteS;
        logic signed [15:0] halfS;
        logic signed [31:0] ext;
        shifted = rdata >> {off, 3'b000};
        byteS   = shifted[7:0];
        halfS   = shifted[15:0];
        case (f3[1:0])
            2'b00: begin
                ext = byteS;
                loadExtract = f3[2] ? {24'd0, shifted[7:0]} : ext;
            end
            2'b01: begin
                ext = halfS;
                loadExtract = f3[2] ? {16'd0, shifted[15:0]} : ext;
            end
            default: loadExtract = rdata;
        endcase
    endfunction

    assign offs     = ALUResultM[1:0];
    assign isLoad   = RegWriteM && (ResultSrcM == 2'b01);
    assign isStore  = MemWriteM;
    assign isAccess = isLoad || isStore;
    assign misalign = isAccess && (((Funct3M[1:0] == 2'b01) && offs[0]) ||
                                   ((Funct3M[1:0] == 2'b10) && (offs != 2'b00)));
    assign accessOk = isAccess && !misalign;
    assign timeout  = (MAX_WAIT != 0) && (waitCnt == CNT_W'(MAX_WAIT));
    assign fmtBe    = isStore ? storeBe(Funct3M, offs) : 4'b1111;
    assign fmtWdata = storeData(Funct3M, WriteDataM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:  if (accessOk && !dmem_ready) nextState = S_WAIT;
            S_WAIT:  if (dmem_ready || timeout)   nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    always_comb begin
        reqRaw     = 1'b0;
        stallRaw   = 1'b0;
        busErrRaw  = 1'b0;
        misRaw     = 1'b0;
        dmem_we    = isStore;
        dmem_addr  = {ALUResultM[31:2], 2'b00};
        dmem_be    = fmtBe;
        dmem_wdata = fmtWdata;
        case (state)
            S_IDLE: begin
                reqRaw   = accessOk;
                stallRaw = accessOk && !dmem_ready;
                misRaw   = misalign;
            end
            S_WAIT: begin
                dmem_we    = latchWe_p0;
                dmem_addr  = latchAddr_p0;
                dmem_be    = latchBe_p0;
                dmem_wdata = latchWdata_p0;
                if (dmem_ready) begin
                    reqRaw = 1'b1;
                end else if (timeout) begin
                    busErrRaw = 1'b1;
                end else begin
                    reqRaw   = 1'b1;
                    stallRaw = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Handshake outputs are killed combinationally for the whole reset window
    assign dmem_req  = reqRaw && rst;
    assign StallM    = stallRaw && rst;
    assign MisalignM = misRaw && rst;
    assign BusErrM   = busErrRaw && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt <= '0;
        end else if (state == S_IDLE && accessOk && !dmem_ready) begin
            waitCnt <= CNT_W'(1);
        end else if (state == S_WAIT && !dmem_ready && !timeout) begin
            waitCnt <= waitCnt + CNT_W'(1);
        end else if (nextState == S_IDLE) begin
            waitCnt <= '0;
        end
    end

    // Bus-field hold registers, captured when an access enters WAIT
    always_ff @(posedge clk) begin
        if (state == S_IDLE && accessOk && !dmem_ready) begin
            latchWe_p0    <= isStore;
            latchAddr_p0  <= {ALUResultM[31:2], 2'b00};
            latchBe_p0    <= fmtBe;
            latchWdata_p0 <= fmtWdata;
        end
    end

    // MEM/WB boundary: stalled edges insert a bubble so WB retires each instruction once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RDW        <= 5'd0;
            ALUResultW <= 32'd0;
            ReadDataW  <= 32'd0;
            PCPlus4W   <= 32'd0;
        end else if (!StallM) begin
            RegWriteW  <= RegWriteM && !MisalignM && !BusErrM;
            ResultSrcW <= ResultSrcM;
            RDW        <= RDM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= loadExtract(Funct3M, offs, dmem_rdata);
            PCPlus4W   <= PCPlus4M;
        end else begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RDW        <= 5'd0;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle: directed load/store/misalign/timeout/reset vectors.
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RDM;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        StallM, MisalignM, BusErrM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RDW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;

    memory_cycle #(.MAX_WAIT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RDM(RDM), .PCPlus4M(PCPlus4M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata),
        .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RDW(RDW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        bit          chkRead;
    } wb_t;

    wb_t         expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic        instValid = 1'b0;
    logic        retire = 1'b0;
    logic [31:0] pcv = 32'h1000;

    int          stallCnt;
    bit          sawReq, sawMis, sawBus, reqAtDone;
    logic [3:0]  beSeen;
    logic [31:0] wdSeen, addrSeen;
    logic        weSeen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: whatever entered MEM/WB on an unstalled edge is popped and compared
    always @(negedge clk) begin
        wb_t e;
        if (retire) begin
            if (expQ.size() == 0) begin
                chk("wb-unexpected-retire", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                chk("wb-RegWriteW", {31'd0, RegWriteW}, {31'd0, e.rw});
                chk("wb-ResultSrcW", {30'd0, ResultSrcW}, {30'd0, e.rs});
                chk("wb-RDW", {27'd0, RDW}, {27'd0, e.rd});
                chk("wb-ALUResultW", ALUResultW, e.alu);
                chk("wb-PCPlus4W", PCPlus4W, e.pc);
                if (e.chkRead) chk("wb-ReadDataW", ReadDataW, e.rdata);
            end
        end
        retire = instValid && rst && !StallM;
    end

    task automatic setNop();
        RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00; Funct3M = 3'b010;
        ALUResultM = 32'd0; WriteDataM = 32'd0; RDM = 5'd0; PCPlus4M = 32'd0;
        instValid = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the instruction leaves MEM.
    // delay: stalled cycles before ready rises; negative means ready never rises.
    task automatic runInst(input logic rw, input logic mw, input logic [1:0] rs,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd,
                           input logic [31:0] rdata, input int delay,
                           input logic expRw, input logic [31:0] expRead, input bit chkRead);
        wb_t e;
        bit  finished;
        pcv = pcv + 32'd4;
        e.rw = expRw; e.rs = rs; e.rd = rd; e.alu = addr; e.rdata = expRead;
        e.pc = pcv; e.chkRead = chkRead;
        expQ.push_back(e);
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; Funct3M = f3;
        ALUResultM = addr; WriteDataM = wd; RDM = rd; PCPlus4M = pcv;
        dmem_rdata = rdata; dmem_ready = (delay == 0); instValid = 1'b1;
        stallCnt = 0; sawReq = 0; sawMis = 0; sawBus = 0; reqAtDone = 0; finished = 0;
        for (int c = 0; c < 40 && !finished; c++) begin
            @(negedge clk);
            if (c == 0) begin
                beSeen = dmem_be; wdSeen = dmem_wdata; addrSeen = dmem_addr; weSeen = dmem_we;
            end else begin
                chk("stall-bubble-RegWriteW", {31'd0, RegWriteW}, 32'd0);
                if (dmem_req)
                    chk("bus-fields-stable", {dmem_be, dmem_addr[27:0]} ^ {beSeen, addrSeen[27:0]} |
                                             (dmem_wdata ^ wdSeen) | {31'd0, dmem_we ^ weSeen}, 32'd0);
            end
            if (dmem_req) sawReq = 1;
            if (MisalignM) sawMis = 1;
            if (BusErrM) sawBus = 1;
            if (StallM) stallCnt++;
            else begin
                finished = 1;
                reqAtDone = dmem_req;
            end
            @(posedge clk); #1;
            dmem_ready = (delay >= 0) && (c + 1 >= delay);
        end
        if (!finished) chk("access-timeout", 32'd1, 32'd0);
        setNop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        setNop();
        repeat (2) @(negedge clk);
        chk("reset-RegWriteW", {31'd0, RegWriteW}, 32'd0);
        chk("reset-RDW-ReadDataW", {27'd0, RDW} | ReadDataW | ALUResultW | PCPlus4W, 32'd0);
        chk("reset-req-stall", {30'd0, dmem_req, StallM}, 32'd0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // LW, ready in the same cycle
        runInst(1, 0, 2'b01, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 1);
        chk("lw-stall", stallCnt, 32'd0);
        chk("lw-be-we", {27'd0, beSeen, weSeen}, {27'd0, 4'b1111, 1'b0});
        chk("lw-addr", addrSeen, 32'h100);

        // Sub-word load extraction
        runInst(1, 0, 2'b01, 3'b000, 32'h103, 32'h0, 5'd6, 32'h80FFFF7F, 0, 1, 32'hFFFFFF80, 1);
        runInst(1, 0, 2'b01, 3'b100, 32'h103, 32'h0, 5'd7, 32'h80FFFF7F, 0, 1, 32'h00000080, 1);
        runInst(1, 0, 2'b01, 3'b001, 32'h102, 32'h0, 5'd8, 32'h80FFFF7F, 0, 1, 32'hFFFF80FF, 1);
        runInst(1, 0, 2'b01, 3'b101, 32'h102, 32'h0, 5'd9, 32'h80FFFF7F, 0, 1, 32'h000080FF, 1);
        runInst(1, 0, 2'b01, 3'b000, 32'h101, 32'h0, 5'd10, 32'h00007F00, 2, 1, 32'h0000007F, 1);
        chk("lb-wait2-stall", stallCnt, 32'd2);

        // SH with ready after three stalled cycles
        runInst(0, 1, 2'b00, 3'b001, 32'h206, 32'h1234ABCD, 5'd0, 32'h0, 3, 0, 32'h0, 0);
        chk("sh-stall", stallCnt, 32'd3);
        chk("sh-be-we", {27'd0, beSeen, weSeen}, {27'd0, 4'b1100, 1'b1});
        chk("sh-wdata", wdSeen, 32'hABCDABCD);
        chk("sh-addr", addrSeen, 32'h204);

        runInst(0, 1, 2'b00, 3'b000, 32'h201, 32'h000000A5, 5'd0, 32'h0, 0, 0, 32'h0, 0);
        chk("sb-be", {28'd0, beSeen}, 32'h2);
        chk("sb-wdata", wdSeen, 32'hA5A5A5A5);
        runInst(0, 1, 2'b00, 3'b010, 32'h208, 32'h11223344, 5'd0, 32'h0, 1, 0, 32'h0, 0);
        chk("sw-stall", stallCnt, 32'd1);
        chk("sw-be-wdata", {beSeen, wdSeen[27:0]}, {4'b1111, 28'h1223344});

        // Misaligned LW is dropped, ADD follows with one-cycle latency
        runInst(1, 0, 2'b01, 3'b010, 32'h101, 32'h0, 5'd11, 32'h0, 0, 0, 32'h0, 0);
        chk("mis-flags", {29'd0, sawMis, sawReq, stallCnt[0]}, {29'd0, 1'b1, 1'b0, 1'b0});
        runInst(1, 0, 2'b00, 3'b000, 32'h55, 32'h0, 5'd12, 32'h0, 0, 1, 32'h0, 0);
        chk("add-noreq", {31'd0, sawReq}, 32'd0);

        // Bus timeout after MAX_WAIT
        runInst(1, 0, 2'b01, 3'b010, 32'h300, 32'h0, 5'd13, 32'h0, -1, 0, 32'h0, 0);
        chk("buserr-stall", stallCnt, 32'd4);
        chk("buserr-pulse-reqdrop", {30'd0, sawBus, reqAtDone}, {30'd0, 1'b1, 1'b0});

        // PC+4 pass-through
        runInst(1, 0, 2'b10, 3'b000, 32'h77, 32'h0, 5'd1, 32'h0, 0, 1, 32'h0, 0);

        // Reset during WAIT cycle 2
        RegWriteM = 1; ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h400;
        RDM = 5'd14; PCPlus4M = 32'h2000; dmem_ready = 0; instValid = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst-pre-stall-req", {30'd0, StallM, dmem_req}, 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("rst-drop-stall-req", {30'd0, StallM, dmem_req}, 32'd0);
        chk("rst-W-cleared", {26'd0, RegWriteW, RDW} | ALUResultW | ReadDataW | PCPlus4W, 32'd0);
        setNop();
        @(negedge clk); #2;
        rst = 1'b1;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h12345678;
        @(negedge clk);
        chk("stray-ready-ignored", {30'd0, StallM, dmem_req}, 32'd0);
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        chk("stray-ready-W", {31'd0, RegWriteW}, 32'd0);

        runInst(1, 0, 2'b01, 3'b010, 32'h300, 32'h0, 5'd9, 32'hCAFEF00D, 0, 1, 32'hCAFEF00D, 1);
        chk("post-rst-lw-stall", stallCnt, 32'd0);

        repeat (3) @(posedge clk);
        chk("scoreboard-drained", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
